// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants, fetch-entry type and counter sizing for the fetch queue
package ifetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 deep synchronous FIFO with flush and occupancy count
module sync_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic [cnt_w(DEPTH)-1:0] cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= wdata_i;
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign rdata_o = mem_q[rd_q];
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order I-mem request issue, PC tagging and decode buffering with redirect flush.
// Define IFETCH_PERF_EN to add perf_stall_cnt/perf_flush_cnt outputs.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] pc_addr,
  output logic pc_hold,
  input  logic redirect,
  output logic mem_req_valid,
  input  logic mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  output logic dec_valid,
  input  logic dec_ready,
  output logic [ILEN-1:0] dec_instr,
  output logic [WIDTH-1:0] dec_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int CW = cnt_w(DEPTH);
  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;
  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, buf_cnt, tag_cnt;
  logic [CW+1:0] reserved;
  logic fire, rsp_ok, rsp_keep, dec_pop;
  logic [WIDTH-1:0] rsp_pc;
  entry_t rsp_entry, head;
  // Every slot that may still land in the buffer (or be dropped) holds a credit
  assign reserved = (CW+2)'(buf_cnt) + (CW+2)'(inflight_q) + (CW+2)'(drop_q);
  assign mem_req_valid = !rst && !redirect && reserved < (CW+2)'(DEPTH);
  assign fire = mem_req_valid && mem_req_ready;
  assign pc_hold = rst || (!fire && !redirect);
  assign mem_req_addr = pc_addr;
  assign rsp_ok = mem_rsp_valid && (inflight_q != '0 || drop_q != '0);
  assign rsp_keep = rsp_ok && drop_q == '0 && !redirect;
  assign rsp_entry = '{pc: rsp_pc, instr: mem_rsp_data};
  assign dec_valid = !rst && !redirect && buf_cnt != '0;
  assign dec_pop = dec_valid && dec_ready;
  assign dec_pc = head.pc;
  assign dec_instr = dec_valid ? head.instr : ILEN'(NOP_INSTR);
  always_comb begin
    inflight_d = redirect ? '0 : inflight_q + CW'(fire) - CW'(rsp_keep);
    drop_d = redirect ? drop_q + inflight_q - CW'(rsp_ok) : drop_q - CW'(rsp_ok && drop_q != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      drop_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q <= drop_d;
    end
  end
  // Tag queue survives redirect: dropped responses still need to retire their tags
  sync_fifo #(.DEPTH(DEPTH), .DW(WIDTH)) u_tag (
    .clk(clk), .rst(rst), .flush_i(1'b0), .push_i(fire), .pop_i(rsp_ok),
    .wdata_i(pc_addr), .rdata_o(rsp_pc), .cnt_o(tag_cnt)
  );
  sync_fifo #(.DEPTH(DEPTH), .DW($bits(entry_t))) u_buf (
    .clk(clk), .rst(rst), .flush_i(redirect), .push_i(rsp_keep), .pop_i(dec_pop),
    .wdata_i(rsp_entry), .rdata_o(head), .cnt_o(buf_cnt)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_rsp_valid && !rsp_ok))
        else $error("ifetch_queue: response with nothing outstanding");
      assert (tag_cnt == inflight_q + drop_q)
        else $error("ifetch_queue: tag queue out of step with counters");
    end
  end
`ifdef IFETCH_PERF_EN
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(!redirect && !fire);
      flush_q <= flush_q + 32'(redirect);
    end
  end
  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed checks of issue, buffering, backpressure and redirect flush
module tb_ifetch_queue;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 0, rst = 1, redirect = 0, mem_req_ready = 0, mem_rsp_valid = 0, dec_ready = 0;
  logic mem_hold = 0;
  logic [31:0] pc_addr = 0, mem_rsp_data = 0, tgt = 0;
  logic pc_hold, mem_req_valid, dec_valid;
  logic [31:0] mem_req_addr, dec_instr, dec_pc;
  int vectors = 0, miscompares = 0, cyc = 0, lat = 1;
  logic [31:0] aq[$];
  int dq[$];
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
  ifetch_queue dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_hold(pc_hold), .redirect(redirect),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
`ifdef IFETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // One clock: memory and PC models react to what the DUT showed before the edge
  task automatic step();
    logic f, h, r;
    logic [31:0] a;
    @(negedge clk);
    f = mem_req_valid && mem_req_ready;
    h = pc_hold;
    r = redirect;
    a = mem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (f) begin
      aq.push_back(a);
      dq.push_back(cyc + lat - 1);
    end
    mem_rsp_valid = 0;
    if (!mem_hold && dq.size() != 0) begin
      if (dq[0] <= cyc) begin
        mem_rsp_valid = 1;
        mem_rsp_data = aq.pop_front() ^ K;
        void'(dq.pop_front());
      end
    end
    if (r) pc_addr = tgt;
    else if (!h) pc_addr += 4;
    redirect = 0;
    #1;
  endtask
  task automatic restart(input logic [31:0] pc0);
    mem_req_ready = 0;
    mem_hold = 0;
    dec_ready = 1;
    for (int i = 0; i < 20 && aq.size() != 0; i++) step();
    step();
    step();
    rst = 1;
    pc_addr = pc0;
    step();
    step();
    rst = 0;
    dec_ready = 0;
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst dec_valid", 32'(dec_valid), 32'd0);
    chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst pc_hold", 32'(pc_hold), 32'd1);
`ifdef IFETCH_PERF_EN
    chk("rst perf_stall", perf_stall_cnt, 32'd0);
    chk("rst perf_flush", perf_flush_cnt, 32'd0);
`endif
    // streaming with a 1-cycle memory
    rst = 0;
    mem_req_ready = 1;
    dec_ready = 1;
    #1;
    chk("s2 issue valid", 32'(mem_req_valid), 32'd1);
    chk("s2 issue hold", 32'(pc_hold), 32'd0);
    chk("s2 issue addr", mem_req_addr, 32'h0);
    step();
    chk("s2 c1 dec_valid", 32'(dec_valid), 32'd0);
    step();
    chk("s2 c2 dec_valid", 32'(dec_valid), 32'd1);
    chk("s2 c2 dec_pc", dec_pc, 32'h0);
    chk("s2 c2 dec_instr", dec_instr, 32'hA5A5_0000);
    step();
    chk("s2 c3 dec_pc", dec_pc, 32'h4);
    chk("s2 c3 dec_instr", dec_instr, 32'hA5A5_0004);
    step();
    chk("s2 c4 dec_pc", dec_pc, 32'h8);
    chk("s2 c4 dec_instr", dec_instr, 32'hA5A5_0008);
    // decode stalled: credit runs out after DEPTH fires
    restart(32'h0);
    mem_req_ready = 1;
    repeat (4) step();
    chk("s3 full valid", 32'(mem_req_valid), 32'd0);
    chk("s3 full hold", 32'(pc_hold), 32'd1);
    chk("s3 full addr", mem_req_addr, 32'h10);
    step();
    chk("s3 c5 valid", 32'(mem_req_valid), 32'd0);
    chk("s3 c5 dec_valid", 32'(dec_valid), 32'd1);
    chk("s3 c5 dec_pc", dec_pc, 32'h0);
    dec_ready = 1;
    step();
    chk("s3 c6 dec_pc", dec_pc, 32'h4);
    chk("s3 c6 resume valid", 32'(mem_req_valid), 32'd1);
    chk("s3 c6 resume addr", mem_req_addr, 32'h10);
    step();
    chk("s3 c7 dec_pc", dec_pc, 32'h8);
    step();
    chk("s3 c8 dec_pc", dec_pc, 32'hC);
    step();
    chk("s3 c9 dec_pc", dec_pc, 32'h10);
    // redirect with 2 in flight and 1 buffered
    restart(32'h0);
    mem_req_ready = 1;
    step();
    mem_hold = 1;
    step();
    step();
    chk("s4 pre dec_valid", 32'(dec_valid), 32'd1);
    chk("s4 pre dec_pc", dec_pc, 32'h0);
    mem_req_ready = 0;
    redirect = 1;
    tgt = 32'h100;
    #1;
    chk("s4 redir dec_valid", 32'(dec_valid), 32'd0);
    chk("s4 redir req_valid", 32'(mem_req_valid), 32'd0);
    step();
    mem_hold = 0;
    mem_req_ready = 1;
    #1;
    chk("s4 c4 req_valid", 32'(mem_req_valid), 32'd1);
    chk("s4 c4 req_addr", mem_req_addr, 32'h100);
    chk("s4 c4 dec_valid", 32'(dec_valid), 32'd0);
    step();
    chk("s4 drop1 dec_valid", 32'(dec_valid), 32'd0);
    step();
    chk("s4 drop2 dec_valid", 32'(dec_valid), 32'd0);
    step();
    chk("s4 c7 dec_valid", 32'(dec_valid), 32'd0);
    step();
    chk("s4 c8 dec_valid", 32'(dec_valid), 32'd1);
    chk("s4 c8 dec_pc", dec_pc, 32'h100);
    chk("s4 c8 dec_instr", dec_instr, 32'hA5A5_0100);
    // memory backpressure, then a redirect
    restart(32'h20);
    dec_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("s5 stall hold", 32'(pc_hold), 32'd1);
      chk("s5 stall valid", 32'(mem_req_valid), 32'd1);
      chk("s5 stall addr", mem_req_addr, 32'h20);
      step();
    end
    mem_req_ready = 1;
    #1;
    chk("s5 fire hold", 32'(pc_hold), 32'd0);
    step();
    chk("s5 next addr", mem_req_addr, 32'h24);
    redirect = 1;
    tgt = 32'h300;
    step();
    chk("s5 target addr", mem_req_addr, 32'h300);
    chk("s5 target valid", 32'(mem_req_valid), 32'd1);
`ifdef IFETCH_PERF_EN
    chk("s6 perf_stall", perf_stall_cnt, 32'd3);
    chk("s6 perf_flush", perf_flush_cnt, 32'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
